sdram_arbiter: RTL
==================

# sdram_arbiter

Round-robin arbiter that shares the single host port of the SDRAM controller between up to NUM_PORTS requesters. It latches one request at a time, drives the controller's read or write enable until the controller acknowledges, then tracks the access to completion and returns read data and a done pulse to the winning port. It sits between the fabric-side masters (bus bridge, video/DMA engines) and the SDRAM controller.

## Interface
- NUM_PORTS, 4: number of requesters, 2..8.
- HADDR_WIDTH, 25: host address width (bank+row+col), matches the controller.
- TIMEOUT, 255: watchdog limit in cycles (used only with watchdog compiled in).
- clk  in  1  system clock, same clock as the SDRAM controller.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_PORTS  per-port request level; held until that port's done.
- req_we  in  NUM_PORTS  per-port 1=write, 0=read; valid while req high.
- req_addr  in  NUM_PORTS*HADDR_WIDTH  packed per-port addresses, port i at [i*HADDR_WIDTH +: HADDR_WIDTH].
- req_wdata  in  NUM_PORTS*8  packed per-port write bytes.
- done  out  NUM_PORTS  one-cycle completion pulse to the served port.
- rdata  out  8  read byte, valid in the cycle done is high for a read.
- err  out  1  one-cycle watchdog abort pulse, coincident with done.
- grant_id  out  $clog2(NUM_PORTS)  index of the port currently owned.
- sd_wr_addr, sd_rd_addr  out  HADDR_WIDTH  to controller; both driven with the latched address.
- sd_wr_data  out  8  to controller.
- sd_wr_enable, sd_rd_enable  out  1  to controller.
- sd_ack, sd_busy, sd_rd_ready  in  1  from controller.
- sd_rd_data  in  8  from controller.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req is high, pick the winner with round-robin priority starting at last_grant+1 (mod NUM_PORTS). Latch addr, we, wdata and grant_id, then go to ISSUE. If no request is pending, stay in IDLE.
- ISSUE: assert sd_rd_enable (read) or sd_wr_enable (write), never both. On sd_ack=1, deassert the enable in the same registered update and go to WAIT_BUSY.
- WAIT_BUSY: wait for sd_busy=1, then go to WAIT_DONE.
- WAIT_DONE: when sd_rd_ready=1 on a read, capture sd_rd_data into rdata. When sd_busy=0, pulse done[grant_id], update last_grant=grant_id, and go to IDLE.
- Request inputs are ignored outside IDLE. Changes to a port's req/addr after it is latched have no effect.
- A port that drops req before it is granted simply loses its turn. No pending state is kept.
- Simultaneous requests: the winner is the first set bit at or after last_grant+1, wrapping around. With NUM_PORTS=4 and last_grant=3, the search order is 0,1,2,3.
- Reset (at any point, including mid-access): state=IDLE, last_grant=NUM_PORTS-1 (so port 0 wins first), both enables 0, done=0, err=0, rdata=0, grant_id=0, latched address/data=0. A controller access already in flight is abandoned, because the controller is reset from the same rst_n.

## Timing
- All outputs are registered. Winner selection is combinational over req, registered on entry to ISSUE.
- Enable rises 1 cycle after req is sampled in IDLE. It is held for at least 1 cycle and falls on the cycle after sd_ack is seen.
- The sd_ack pulse from the controller is 1 cycle wide. The enable is deasserted before the controller returns to idle, so the access is never double-issued.
- done is 1 cycle wide, on the cycle after sd_busy is sampled low in WAIT_DONE.
- Minimum gap between two grants: 1 IDLE cycle.

## Configuration
- SDRAM_ARB_WATCHDOG_EN defined:
  - A cycle counter runs in ISSUE, WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT, the arbiter drops the enables, pulses done[grant_id] and err together, sets rdata=0, and goes to IDLE.
  - The counter clears on every state change.
- SDRAM_ARB_WATCHDOG_EN undefined: no counter, err is tied to 0, and the FSM waits indefinitely.

## Structure
- Shared package sdram_pkg: the state encoding constant and default HADDR_WIDTH/data-width constants, shared with the controller and its testbench.
- One sub-module, sdram_arb_rr:
  - Combinational round-robin picker with inputs req[NUM_PORTS] and last_grant.
  - Outputs are a valid flag and the winner index.

## Test plan
- Single read: port 2 read of 0x0000123; the controller model acks after 1 cycle and returns 0xA5 -> sd_rd_enable is high for exactly the cycles up to and including ack, done=4'b0100 once, rdata=0xA5.
- Single write: port 0 write of 0x3C to 0x1FFFFFF -> sd_wr_data=0x3C, sd_wr_addr=0x1FFFFFF, sd_rd_enable never high, done=4'b0001.
- Fairness: all four ports hold req continuously for 8 accesses -> grant order 0,1,2,3,0,1,2,3, with no port granted twice in a row.
- Wrap-around: after port 3 is served, ports 1 and 3 request together -> port 1 wins.
- Reset mid-access: assert rst_n low during WAIT_BUSY -> all enables, done and err are 0 in that cycle. After release, the next grant goes to port 0.
- Watchdog (with SDRAM_ARB_WATCHDOG_EN, TIMEOUT=16): the controller never acks -> after 16 cycles in ISSUE, done and err pulse together and the enable drops. Without the macro, the arbiter stays in ISSUE.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: address/data widths and the arbiter FSM encoding, shared by the
// SDRAM controller, the host-port arbiter and their benches.
package sdram_pkg;
    localparam int SDRAM_HADDR_W = 25;
    localparam int SDRAM_DATA_W  = 8;
    localparam int ARB_STATE_W   = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;
endpackage

// File: rtl/sdram_arb_rr.sv
// sdram_arb_rr: combinational round-robin picker. The first requesting port
// after i_last_grant wins, wrapping back to port 0 when none is above it.
module sdram_arb_rr #(
    parameter int NUM_PORTS = 4,
    parameter int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IW-1:0]        i_last_grant,
    output logic                 o_valid,
    output logic [IW-1:0]        o_idx
);
    logic [NUM_PORTS-1:0] w_hi;

    always_comb begin
        logic found;
        found   = 1'b0;
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            w_hi[i] = i_req[i] && (i > int'(i_last_grant));
        // Ports above the last winner take precedence over the wrapped ones.
        for (int i = 0; i < NUM_PORTS; i++)
            if (!found && w_hi[i]) begin
                o_idx = IW'(i);
                found = 1'b1;
            end
        for (int i = 0; i < NUM_PORTS; i++)
            if (!found && i_req[i]) begin
                o_idx = IW'(i);
                found = 1'b1;
            end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller host port between NUM_PORTS masters.
// Define SDRAM_ARB_WATCHDOG_EN to compile in the TIMEOUT abort watchdog (drives err).
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int HADDR_WIDTH = SDRAM_HADDR_W,
    parameter int TIMEOUT     = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               req,
    input  logic [NUM_PORTS-1:0]               req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_PORTS*SDRAM_DATA_W-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]               done,
    output logic [SDRAM_DATA_W-1:0]            rdata,
    output logic                               err,
    output logic [$clog2(NUM_PORTS)-1:0]       grant_id,
    output logic [HADDR_WIDTH-1:0]             sd_wr_addr,
    output logic [HADDR_WIDTH-1:0]             sd_rd_addr,
    output logic [SDRAM_DATA_W-1:0]            sd_wr_data,
    output logic                               sd_wr_enable,
    output logic                               sd_rd_enable,
    input  logic                               sd_ack,
    input  logic                               sd_busy,
    input  logic                               sd_rd_ready,
    input  logic [SDRAM_DATA_W-1:0]            sd_rd_data
);
    localparam int GW = $clog2(NUM_PORTS);
    localparam int DW = SDRAM_DATA_W;

    arb_state_t             r_state, w_state;
    logic [GW-1:0]          r_last, w_last, w_win, w_gid;
    logic                   w_valid, r_we, w_we, w_wr_en, w_rd_en, w_wd_hit;
    logic [HADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DW-1:0]          r_wdata, w_wdata, w_rdata;
    logic [NUM_PORTS-1:0]   w_done;
    logic [HADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
    logic [DW-1:0]          w_wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*HADDR_WIDTH +: HADDR_WIDTH];
        assign w_wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    sdram_arb_rr #(.NUM_PORTS(NUM_PORTS), .IW(GW)) u_rr (
        .i_req        (req),
        .i_last_grant (r_last),
        .o_valid      (w_valid),
        .o_idx        (w_win)
    );

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wd_cnt;
    logic           r_err;

    assign w_wd_hit = (r_state != IDLE) && (r_wd_cnt == WDW'(TIMEOUT - 1));
    assign err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err    <= w_wd_hit;
            r_wd_cnt <= (w_state != r_state || r_state == IDLE) ? '0 : r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_wd_hit = 1'b0;
    // Constant 0; the comparison only keeps TIMEOUT referenced in this build.
    assign err      = (TIMEOUT < 0);
`endif

    always_comb begin
        w_state = r_state;
        w_last  = r_last;
        w_gid   = grant_id;
        w_we    = r_we;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_rdata = rdata;
        w_wr_en = sd_wr_enable;
        w_rd_en = sd_rd_enable;
        w_done  = '0;
        case (r_state)
            IDLE: if (w_valid) begin
                w_state = ISSUE;
                w_gid   = w_win;
                w_we    = req_we[w_win];
                w_addr  = w_addr_arr[w_win];
                w_wdata = w_wdata_arr[w_win];
                w_wr_en = req_we[w_win];
                w_rd_en = !req_we[w_win];
            end
            // Enable drops in the same update that sees ack, so it never re-issues.
            ISSUE: if (sd_ack) begin
                w_state = WAIT_BUSY;
                w_wr_en = 1'b0;
                w_rd_en = 1'b0;
            end
            WAIT_BUSY: if (sd_busy) w_state = WAIT_DONE;
            WAIT_DONE: begin
                if (sd_rd_ready && !r_we) w_rdata = sd_rd_data;
                if (!sd_busy) begin
                    w_state          = IDLE;
                    w_done[grant_id] = 1'b1;
                    w_last           = grant_id;
                end
            end
        endcase
        if (w_wd_hit) begin
            w_state          = IDLE;
            w_wr_en          = 1'b0;
            w_rd_en          = 1'b0;
            w_rdata          = '0;
            w_done           = '0;
            w_done[grant_id] = 1'b1;
            w_last           = grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last       <= GW'(NUM_PORTS - 1);
            grant_id     <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            rdata        <= '0;
            done         <= '0;
            sd_wr_enable <= 1'b0;
            sd_rd_enable <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last       <= w_last;
            grant_id     <= w_gid;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            rdata        <= w_rdata;
            done         <= w_done;
            sd_wr_enable <= w_wr_en;
            sd_rd_enable <= w_rd_en;
        end
    end

    assign sd_wr_addr = r_addr;
    assign sd_rd_addr = r_addr;
    assign sd_wr_data = r_wdata;
endmodule
